// File: rtl/layer_compositor_pkg.sv
// Shared types, constants and pair-index helpers for the layer compositor.
// Optional feature macro used by this block: LAYER_COMPOSITOR_COLLISION_CNT_EN.
package layer_compositor_pkg;

  localparam int CW = 8;

  typedef struct packed {
    logic [CW-1:0] r;
    logic [CW-1:0] g;
    logic [CW-1:0] b;
  } rgb_t;

  localparam logic BLEND_PRIORITY = 1'b0;
  localparam logic BLEND_OR       = 1'b1;

  // Number of unordered layer pairs.
  function automatic int n_pairs(input int n);
    return (n * (n - 1)) / 2;
  endfunction

  // Flat index of pair (i,j), i<j, in row-major upper-triangle order.
  function automatic int pair_index(input int i, input int j, input int n);
    return (i * n) - ((i * (i + 1)) / 2) + (j - i - 1);
  endfunction

endpackage

// File: rtl/layer_compositor_collision_tracker.sv
// Per-pair overlap detection on the stage-1 pixel registers, a sticky
// per-frame accumulator, the frame-boundary latch and the frame counter.
// With LAYER_COMPOSITOR_COLLISION_CNT_EN defined it also keeps saturating
// per-pair overlap pixel counts.
module layer_compositor_collision_tracker
  import layer_compositor_pkg::*;
#(
  parameter int  N_LAYERS = 4,
  localparam int N_PAIRS  = n_pairs(N_LAYERS)
) (
  input  logic                  pixel_clk,
  input  logic                  rst,
  input  logic                  fsync,
  input  logic                  s1_active,
  input  logic [N_LAYERS-1:0]   s1_layer_active,
  output logic [N_PAIRS-1:0]    collision_flags,
  output logic                  collision_any,
  output logic [15:0]           frame_count
`ifdef LAYER_COMPOSITOR_COLLISION_CNT_EN
  ,
  output logic [N_PAIRS*16-1:0] collision_count
`endif
);

  logic [N_PAIRS-1:0] overlap;
  logic [N_PAIRS-1:0] acc;
  logic [N_PAIRS-1:0] acc_next;

  // Overlap of every layer pair on the current visible stage-1 pixel.
  always_comb begin
    overlap = '0;
    for (int i = 0; i < N_LAYERS - 1; i++) begin
      for (int j = i + 1; j < N_LAYERS; j++) begin
        overlap[pair_index(i, j, N_LAYERS)] = s1_active & s1_layer_active[i] & s1_layer_active[j];
      end
    end
  end

  assign acc_next = acc | overlap;

  // Sticky accumulator, frame-boundary latch and completed-frame counter.
  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      acc             <= '0;
      collision_flags <= '0;
      collision_any   <= 1'b0;
      frame_count     <= 16'd0;
    end else begin
      // The OR is taken from the already-latched flags, so it trails them by one cycle.
      collision_any <= |collision_flags;
      if (fsync) begin
        collision_flags <= acc_next;
        acc             <= '0;
        frame_count     <= frame_count + 16'd1;
      end else begin
        acc <= acc_next;
      end
    end
  end

`ifdef LAYER_COMPOSITOR_COLLISION_CNT_EN
  logic [15:0] pair_cnt      [N_PAIRS];
  logic [15:0] pair_cnt_next [N_PAIRS];

  // Saturating increment of each running pair count.
  always_comb begin
    for (int k = 0; k < N_PAIRS; k++) begin
      pair_cnt_next[k] = pair_cnt[k];
      if (overlap[k] && (pair_cnt[k] != 16'hFFFF)) begin
        pair_cnt_next[k] = pair_cnt[k] + 16'd1;
      end
    end
  end

  // Running counts restart at each frame boundary; the finished totals are latched.
  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      // NOTE: this array is small control state with a defined reset value, so
      // every entry is cleared explicitly; large data RAMs would not be reset.
      for (int k = 0; k < N_PAIRS; k++) begin
        pair_cnt[k] <= 16'd0;
      end
      collision_count <= '0;
    end else if (fsync) begin
      for (int k = 0; k < N_PAIRS; k++) begin
        collision_count[k*16 +: 16] <= pair_cnt_next[k];
        pair_cnt[k]                 <= 16'd0;
      end
    end else begin
      for (int k = 0; k < N_PAIRS; k++) begin
        pair_cnt[k] <= pair_cnt_next[k];
      end
    end
  end
`endif

endmodule

// File: rtl/layer_compositor.sv
// Layer compositor: merges N_LAYERS sprite/overlay layers into one RGB pixel
// stream through a fixed 2-cycle pipeline, in priority or OR blend mode, and
// reports per-frame layer-pair collisions.
// Optional feature macro: LAYER_COMPOSITOR_COLLISION_CNT_EN (adds collision_count).
module layer_compositor
  import layer_compositor_pkg::*;
#(
  parameter int          N_LAYERS = 4,
  parameter int          CW       = 8,
  parameter logic [23:0] BG_COLOR = 24'h000000,
  localparam int         N_PAIRS  = n_pairs(N_LAYERS)
) (
  input  logic                     pixel_clk,
  input  logic                     rst,
  input  logic                     fsync,
  input  logic                     active,
  input  logic [N_LAYERS-1:0]      layer_active,
  input  logic [N_LAYERS*3*CW-1:0] layer_pixel,
  input  logic                     blend_mode_req,
  output logic [3*CW-1:0]          pixel_out,
  output logic                     pixel_active,
  output logic                     blend_mode,
  output logic [N_PAIRS-1:0]       collision_flags,
  output logic                     collision_any,
  output logic [15:0]              frame_count
`ifdef LAYER_COMPOSITOR_COLLISION_CNT_EN
  ,
  output logic [N_PAIRS*16-1:0]    collision_count
`endif
);

  localparam int              PW     = 3 * CW;
  localparam logic [PW-1:0]   BG_PIX = PW'(BG_COLOR);

  logic                     s1_active;
  logic [N_LAYERS-1:0]      s1_layer_active;
  logic [N_LAYERS*PW-1:0]   s1_pixel;
  logic                     s1_mode;
  logic [PW-1:0]            comp;

  // Mode register: only a frame-start pulse may change the blend mode.
  always_ff @(posedge pixel_clk) begin
    // NOTE: sequential state always uses non-blocking assignments so every
    // register samples pre-edge values regardless of block ordering.
    if (rst) begin
      blend_mode <= BLEND_PRIORITY;
    end else if (fsync) begin
      blend_mode <= blend_mode_req;
    end
  end

  // Stage 1: register the raw inputs; the mode travels with the pixel so
  // pixels already in flight at fsync finish in the old mode.
  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      s1_active       <= 1'b0;
      s1_layer_active <= '0;
      s1_pixel        <= '0;
      s1_mode         <= BLEND_PRIORITY;
    end else begin
      s1_active       <= active;
      s1_layer_active <= layer_active;
      s1_pixel        <= layer_pixel;
      s1_mode         <= blend_mode;
    end
  end

  // Composite of the stage-1 pixel: blank, background, priority or OR blend.
  always_comb begin
    // NOTE: default first so no path through this block leaves comp unassigned
    // (which would infer a latch).
    comp = '0;
    if (!s1_active) begin
      comp = '0;
    end else if (s1_layer_active == '0) begin
      comp = BG_PIX;
    end else if (s1_mode == BLEND_PRIORITY) begin
      // Walk from lowest priority upward so the lowest active index wins.
      for (int i = N_LAYERS - 1; i >= 0; i--) begin
        if (s1_layer_active[i]) begin
          comp = s1_pixel[i*PW +: PW];
        end
      end
    end else begin
      for (int i = 0; i < N_LAYERS; i++) begin
        if (s1_layer_active[i]) begin
          comp = comp | s1_pixel[i*PW +: PW];
        end
      end
    end
  end

  // Stage 2: register the composite result and its visibility qualifier.
  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      pixel_out    <= '0;
      pixel_active <= 1'b0;
    end else begin
      pixel_out    <= comp;
      pixel_active <= s1_active;
    end
  end

  layer_compositor_collision_tracker #(
    .N_LAYERS (N_LAYERS)
  ) u_collision_tracker (
    .pixel_clk       (pixel_clk),
    .rst             (rst),
    .fsync           (fsync),
    .s1_active       (s1_active),
    .s1_layer_active (s1_layer_active),
    .collision_flags (collision_flags),
    .collision_any   (collision_any),
    .frame_count     (frame_count)
`ifdef LAYER_COMPOSITOR_COLLISION_CNT_EN
    ,
    .collision_count (collision_count)
`endif
  );

endmodule

// File: tb/tb_layer_compositor.sv
// Directed self-checking bench for layer_compositor (N_LAYERS=4, CW=8,
// BG_COLOR=0x202020). Inputs change just after the falling edge and outputs
// are sampled at the falling edge, half a cycle away from the active edge.
module tb_layer_compositor;
  import layer_compositor_pkg::*;

  localparam int N_LAYERS = 4;
  localparam int N_PAIRS  = 6;

  logic                  pixel_clk;
  logic                  rst;
  logic                  fsync;
  logic                  active;
  logic [N_LAYERS-1:0]   layer_active;
  logic [N_LAYERS*24-1:0] layer_pixel;
  logic                  blend_mode_req;
  logic [23:0]           pixel_out;
  logic                  pixel_active;
  logic                  blend_mode;
  logic [N_PAIRS-1:0]    collision_flags;
  logic                  collision_any;
  logic [15:0]           frame_count;
`ifdef LAYER_COMPOSITOR_COLLISION_CNT_EN
  logic [N_PAIRS*16-1:0] collision_count;
`endif

  int vectors     = 0;
  int miscompares = 0;
  int exp_fc      = 0;

  layer_compositor #(
    .N_LAYERS (N_LAYERS),
    .CW       (8),
    .BG_COLOR (24'h202020)
  ) dut (
    .pixel_clk       (pixel_clk),
    .rst             (rst),
    .fsync           (fsync),
    .active          (active),
    .layer_active    (layer_active),
    .layer_pixel     (layer_pixel),
    .blend_mode_req  (blend_mode_req),
    .pixel_out       (pixel_out),
    .pixel_active    (pixel_active),
    .blend_mode      (blend_mode),
    .collision_flags (collision_flags),
    .collision_any   (collision_any),
    .frame_count     (frame_count)
`ifdef LAYER_COMPOSITOR_COLLISION_CNT_EN
    ,
    .collision_count (collision_count)
`endif
  );

  initial pixel_clk = 1'b0;
  always #5 pixel_clk = ~pixel_clk;

  // Advance one full clock: returns at the next falling edge.
  task automatic tick();
    @(negedge pixel_clk);
  endtask

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic idle();
    active       = 1'b0;
    layer_active = '0;
  endtask

  initial begin
    rgb_t l0, l1, l2, l3;
    l0 = '{r: 8'hAA, g: 8'hAA, b: 8'hAA};
    l1 = '{r: 8'h11, g: 8'h22, b: 8'h33};
    l2 = '{r: 8'h55, g: 8'h55, b: 8'h55};
    l3 = '{r: 8'h00, g: 8'hFF, b: 8'h00};

    rst            = 1'b1;
    fsync          = 1'b0;
    blend_mode_req = 1'b0;
    layer_pixel    = {l3, l2, l1, l0};
    idle();
    tick();
    tick();

    // Reset state
    check("rst_pixel_out",    64'(pixel_out),       64'h0);
    check("rst_pixel_active", 64'(pixel_active),    64'h0);
    check("rst_blend_mode",   64'(blend_mode),      64'h0);
    check("rst_flags",        64'(collision_flags), 64'h0);
    check("rst_any",          64'(collision_any),   64'h0);
    check("rst_frame_count",  64'(frame_count),     64'h0);
    rst = 1'b0;

    // 1. Priority mode: layers 1 and 3 active, layer 1 wins
    active = 1'b1; layer_active = 4'b1010;
    tick();
    idle();
    tick();
    check("prio_pixel",  64'(pixel_out),    64'h112233);
    check("prio_active", 64'(pixel_active), 64'h1);

    // 2. Switch to OR mode at a frame boundary
    fsync = 1'b1; blend_mode_req = 1'b1;
    tick();
    fsync = 1'b0; blend_mode_req = 1'b0; exp_fc++;
    check("mode_after_fsync", 64'(blend_mode),      64'h1);
    check("fc_frame1",        64'(frame_count),     64'(exp_fc));
    check("flags_pair13",     64'(collision_flags), 64'b010000);
    active = 1'b1; layer_active = 4'b1010;
    tick();
    idle();
    tick();
    check("or_pixel", 64'(pixel_out), 64'h11FF33);
    // blend_mode_req stays 0 without fsync: mode must not change
    tick();
    tick();
    check("mode_ignores_req", 64'(blend_mode), 64'h1);

    // Switch back; the fsync-cycle pixel still composites in OR mode
    fsync = 1'b1; blend_mode_req = 1'b0; active = 1'b1; layer_active = 4'b1010;
    tick();
    fsync = 1'b0; exp_fc++;
    tick();
    check("fsync_pixel_old_mode", 64'(pixel_out), 64'h11FF33);
    idle();
    tick();
    check("next_pixel_new_mode", 64'(pixel_out),  64'h112233);
    check("mode_back_prio",      64'(blend_mode), 64'h0);

    // 3. Background and blanking
    active = 1'b1; layer_active = 4'b0000;
    tick();
    idle();
    tick();
    check("bg_pixel",  64'(pixel_out),    64'h202020);
    check("bg_active", 64'(pixel_active), 64'h1);
    active = 1'b0; layer_active = 4'b1111;
    tick();
    idle();
    tick();
    check("blank_pixel",  64'(pixel_out),    64'h0);
    check("blank_active", 64'(pixel_active), 64'h0);

    // 4. Collisions: clean frame start, then (0,2) visible x5, (1,2) blanked x3
    fsync = 1'b1;
    tick();
    fsync = 1'b0; exp_fc++;
    active = 1'b1; layer_active = 4'b0101;
    repeat (5) tick();
    active = 1'b0; layer_active = 4'b0110;
    repeat (3) tick();
    idle();
    tick();
    fsync = 1'b1;
    tick();
    fsync = 1'b0; exp_fc++;
    check("flags_pair02", 64'(collision_flags), 64'b000010);
    check("fc_frame4",    64'(frame_count),     64'(exp_fc));
`ifdef LAYER_COMPOSITOR_COLLISION_CNT_EN
    check("cnt_pair1", 64'(collision_count[1*16 +: 16]), 64'd5);
    check("cnt_others", 64'({collision_count[95:32], collision_count[15:0]}), 64'h0);
`endif
    tick();
    check("any_after_pair02", 64'(collision_any), 64'h1);

    // Overlap (2,3) held in stage 1 during the fsync cycle is included
    tick();
    active = 1'b1; layer_active = 4'b1100;
    tick();
    idle(); fsync = 1'b1;
    tick();
    fsync = 1'b0; exp_fc++;
    check("flags_edge_pair23", 64'(collision_flags), 64'b100000);
`ifdef LAYER_COMPOSITOR_COLLISION_CNT_EN
    check("cnt_pair5", 64'(collision_count[5*16 +: 16]), 64'd1);
`endif

    // Frame with no overlap latches zero; collision_any follows one cycle later
    repeat (3) tick();
    fsync = 1'b1;
    tick();
    fsync = 1'b0; exp_fc++;
    check("flags_empty",      64'(collision_flags), 64'h0);
    check("any_still_old",    64'(collision_any),   64'h1);
    check("fc_frame6",        64'(frame_count),     64'(exp_fc));
    tick();
    check("any_cleared",      64'(collision_any),   64'h0);

    // 5. Reset mid-frame after overlaps
    active = 1'b1; layer_active = 4'b0011;
    tick();
    tick();
    rst = 1'b1;
    tick();
    check("midrst_pixel", 64'(pixel_out),       64'h0);
    check("midrst_flags", 64'(collision_flags), 64'h0);
    check("midrst_fc",    64'(frame_count),     64'h0);
    rst = 1'b0; idle(); exp_fc = 0;
    tick();
    check("midrst_flush", 64'(pixel_out), 64'h0);
    fsync = 1'b1;
    tick();
    fsync = 1'b0; exp_fc++;
    check("postrst_flags", 64'(collision_flags), 64'h0);
    check("postrst_fc",    64'(frame_count),     64'(exp_fc));

    // 6. Frame counter wrap via back-to-back fsyncs
    fsync = 1'b1;
    repeat (65534) tick();
    check("fc_max", 64'(frame_count), 64'hFFFF);
    tick();
    fsync = 1'b0;
    check("fc_wrap",       64'(frame_count),     64'h0);
    check("b2b_flags",     64'(collision_flags), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
